// File: rtl/mmio_defs.sv
// Shared register map and bit positions for the memory-mapped transmit FIFO.
package mmio_defs;

  localparam logic [31:0] DATA_OFF   = 32'd0;
  localparam logic [31:0] STATUS_OFF = 32'd4;
  localparam logic [31:0] CTRL_OFF   = 32'd8;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_INT_EN    = 3;
  localparam int ST_IRQ_PEND  = 4;
  localparam int ST_COUNT_LSB = 8;

  localparam int CTRL_INT_EN  = 0;
  localparam int CTRL_CLR_OVF = 1;
  localparam int CTRL_CLR_IRQ = 2;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_DATA,
    REG_STATUS,
    REG_CTRL
  } reg_sel_e;

  function automatic reg_sel_e decodeReg(input logic [31:0] addr, input logic [31:0] base);
    if (addr == base + DATA_OFF)        return REG_DATA;
    else if (addr == base + STATUS_OFF) return REG_STATUS;
    else if (addr == base + CTRL_OFF)   return REG_CTRL;
    else                                return REG_NONE;
  endfunction

endpackage

// File: rtl/fifo_core.sv
// Byte FIFO storage with wrapping pointers and an occupancy count.
module fifo_core #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [PTR_W:0]   count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             doPush, doPop;

  assign full_o  = (count_q == FULL_COUNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rdPtr_q];

  // A push into a full FIFO or a pop from an empty one is simply ignored here.
  assign doPush = push_i & ~full_o;
  assign doPop  = pop_i & ~empty_o;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) wrPtr_d = wrPtr_q + PTR_W'(1);
    if (doPop)  rdPtr_d = rdPtr_q + PTR_W'(1);
    case ({doPush, doPop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage is left out of reset; stale entries are never visible while empty.
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= wdata_i;
  end

endmodule

// File: rtl/mmio_tx_fifo.sv
// Memory-mapped transmit FIFO: CPU stores push bytes, a valid/ready stream drains them,
// and an interrupt is raised when the FIFO drains empty.
module mmio_tx_fifo
  import mmio_defs::*;
#(
  parameter int          DEPTH = 8,
  parameter int          PTR_W = 3,
  parameter logic [31:0] BASE  = 32'hffff0080
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data,
  input  logic [31:0] address,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] cpu_rdata,
  output logic        fifo_address,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        interrupt
);

  reg_sel_e       regSel;
  logic           pushReq, pushAccepted, pop, ctrlWrite, drainEdge;
  logic [PTR_W:0] count;
  logic           full, empty;
  logic           overflow_q, overflow_d;
  logic           intEnable_q, intEnable_d;
  logic           irqPending_q, irqPending_d;
  logic [31:0]    status;

  assign regSel       = decodeReg(address, BASE);
  assign fifo_address = (regSel != REG_NONE);

  assign pushReq      = MemWrite & (regSel == REG_DATA);
  assign pushAccepted = pushReq & ~full;
  assign ctrlWrite    = MemWrite & (regSel == REG_CTRL);
  assign tx_valid     = ~empty;
  assign pop          = tx_valid & tx_ready;
  assign drainEdge    = pop & ~pushAccepted & (count == (PTR_W + 1)'(1));

  fifo_core #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .WIDTH (8)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .push_i  (pushReq),
    .pop_i   (pop),
    .wdata_i (data[7:0]),
    .rdata_o (tx_data),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  // Sets are applied after CTRL clears so a same-edge event is never lost.
  always_comb begin
    overflow_d   = overflow_q;
    intEnable_d  = intEnable_q;
    irqPending_d = irqPending_q;
    if (ctrlWrite) begin
      intEnable_d = data[CTRL_INT_EN];
      if (data[CTRL_CLR_OVF]) overflow_d   = 1'b0;
      if (data[CTRL_CLR_IRQ]) irqPending_d = 1'b0;
    end
    if (pushReq & full) overflow_d   = 1'b1;
    if (drainEdge)      irqPending_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q   <= 1'b0;
      intEnable_q  <= 1'b0;
      irqPending_q <= 1'b0;
    end else begin
      overflow_q   <= overflow_d;
      intEnable_q  <= intEnable_d;
      irqPending_q <= irqPending_d;
    end
  end

  assign interrupt = irqPending_q & intEnable_q;

  always_comb begin
    status                             = '0;
    status[ST_EMPTY]                   = empty;
    status[ST_FULL]                    = full;
    status[ST_OVERFLOW]                = overflow_q;
    status[ST_INT_EN]                  = intEnable_q;
    status[ST_IRQ_PEND]                = irqPending_q;
    status[ST_COUNT_LSB +: (PTR_W + 1)] = count;
  end

  // DATA reads back as zero; CTRL reads mirror STATUS.
  always_comb begin
    cpu_rdata = '0;
    if (MemRead) begin
      case (regSel)
        REG_STATUS, REG_CTRL: cpu_rdata = status;
        default:              cpu_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_tx_fifo.sv
// Directed bench for mmio_tx_fifo: a decode vector table plus hand-written
// sequences for fill, drain, overflow, interrupt and asynchronous reset.
module tb_mmio_tx_fifo;

  localparam logic [31:0] BASE = 32'hffff0080;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data;
  logic [31:0] address;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] cpu_rdata;
  logic        fifo_address;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        interrupt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] addr;
    logic        rd;
    logic        expHit;
    logic [31:0] expRdata;
  } decodeVec_t;

  decodeVec_t vecs [9];

  mmio_tx_fifo #(
    .DEPTH (8),
    .PTR_W (3),
    .BASE  (BASE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .data         (data),
    .address      (address),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .cpu_rdata    (cpu_rdata),
    .fifo_address (fifo_address),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .interrupt    (interrupt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input decodeVec_t v);
    address = v.addr;
    MemRead = v.rd;
    #1;
  endtask

  task automatic cpuWrite(input logic [31:0] addr, input logic [31:0] wdata);
    address  = addr;
    data     = wdata;
    MemWrite = 1'b1;
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    address  = 32'h0;
  endtask

  task automatic readStatus(input string name, input logic [31:0] expected);
    address = BASE + 32'd4;
    MemRead = 1'b1;
    #1;
    checkOutput(name, cpu_rdata, expected);
    MemRead = 1'b0;
    address = 32'h0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{BASE,               1'b1, 1'b1, 32'h0};
    vecs[1] = '{BASE + 32'd4,       1'b1, 1'b1, 32'h1};
    vecs[2] = '{BASE + 32'd8,       1'b1, 1'b1, 32'h1};
    vecs[3] = '{BASE + 32'd4,       1'b0, 1'b1, 32'h0};
    vecs[4] = '{BASE + 32'd12,      1'b1, 1'b0, 32'h0};
    vecs[5] = '{BASE - 32'd4,       1'b1, 1'b0, 32'h0};
    vecs[6] = '{BASE + 32'd1,       1'b1, 1'b0, 32'h0};
    vecs[7] = '{32'h0000_0084,      1'b1, 1'b0, 32'h0};
    vecs[8] = '{32'hffff_0180,      1'b1, 1'b0, 32'h0};

    reset    = 1'b0;
    data     = 32'h0;
    address  = 32'h0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    tx_ready = 1'b0;

    #12;
    checkOutput("tx_valid in reset", 32'(tx_valid), 32'h0);
    checkOutput("interrupt in reset", 32'(interrupt), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    address = BASE + 32'd4;
    MemRead = 1'b1;
    #1;
    checkOutput("status after reset", cpu_rdata, 32'h0000_0001);
    checkOutput("tx_valid after reset", 32'(tx_valid), 32'h0);
    checkOutput("interrupt after reset", 32'(interrupt), 32'h0);
    checkOutput("decode hit status", 32'(fifo_address), 32'h1);
    MemRead = 1'b0;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("decode hit vec%0d", i), 32'(fifo_address), 32'(vecs[i].expHit));
      checkOutput($sformatf("decode rdata vec%0d", i), cpu_rdata, vecs[i].expRdata);
    end
    MemRead = 1'b0;
    address = 32'h0;

    // Three pushes; upper data bits must be ignored.
    cpuWrite(BASE, 32'hdeadbe41);
    cpuWrite(BASE, 32'h00000042);
    cpuWrite(BASE, 32'h12345643);
    readStatus("status three bytes", 32'h0000_0300);
    checkOutput("head after three pushes", 32'(tx_data), 32'h41);
    checkOutput("valid after three pushes", 32'(tx_valid), 32'h1);
    address = BASE;
    MemRead = 1'b1;
    #1;
    checkOutput("data reg reads zero", cpu_rdata, 32'h0);
    MemRead = 1'b0;

    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("drain3 byte%0d", i), 32'(tx_data), 32'h41 + 32'(i));
      @(posedge clk);
      #1;
    end
    tx_ready = 1'b0;
    readStatus("status after drain3", 32'h0000_0011);
    cpuWrite(BASE + 32'd8, 32'h4);
    readStatus("status after irq clear", 32'h0000_0001);

    // Fill past capacity: ninth byte dropped, overflow set.
    for (int i = 0; i < 9; i++) cpuWrite(BASE, 32'(i));
    readStatus("status overflowed", 32'h0000_0806);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("drain8 valid%0d", i), 32'(tx_valid), 32'h1);
      checkOutput($sformatf("drain8 byte%0d", i), 32'(tx_data), 32'(i));
      @(posedge clk);
      #1;
    end
    checkOutput("valid after drain8", 32'(tx_valid), 32'h0);
    tx_ready = 1'b0;
    readStatus("status after drain8", 32'h0000_0015);
    checkOutput("interrupt masked", 32'(interrupt), 32'h0);

    // Enable interrupt, push one byte and let it drain straight away.
    cpuWrite(BASE + 32'd8, 32'h7);
    readStatus("status after ctrl 7", 32'h0000_0009);
    tx_ready = 1'b1;
    cpuWrite(BASE, 32'h55);
    checkOutput("single byte valid", 32'(tx_valid), 32'h1);
    checkOutput("single byte data", 32'(tx_data), 32'h55);
    checkOutput("interrupt before drain", 32'(interrupt), 32'h0);
    @(posedge clk);
    #1;
    checkOutput("interrupt after drain", 32'(interrupt), 32'h1);
    checkOutput("valid after drain", 32'(tx_valid), 32'h0);
    tx_ready = 1'b0;
    readStatus("status irq pending", 32'h0000_0019);
    cpuWrite(BASE + 32'd8, 32'h5);
    checkOutput("interrupt cleared", 32'(interrupt), 32'h0);
    readStatus("status int_en kept", 32'h0000_0009);

    // Push and pop on the same edge while full, then while partly full.
    for (int i = 0; i < 8; i++) cpuWrite(BASE, 32'h10 + 32'(i));
    readStatus("status full", 32'h0000_080a);
    tx_ready = 1'b1;
    cpuWrite(BASE, 32'haa);
    tx_ready = 1'b0;
    readStatus("status push+pop full", 32'h0000_070c);
    checkOutput("head after push+pop full", 32'(tx_data), 32'h11);
    tx_ready = 1'b1;
    cpuWrite(BASE, 32'hbb);
    tx_ready = 1'b0;
    readStatus("status push+pop mid", 32'h0000_070c);
    checkOutput("head after push+pop mid", 32'(tx_data), 32'h12);

    // Drain down to five entries, then reset asynchronously between edges.
    tx_ready = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checkOutput("valid at count5", 32'(tx_valid), 32'h1);
    checkOutput("head at count5", 32'(tx_data), 32'h14);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("valid async reset", 32'(tx_valid), 32'h0);
    checkOutput("interrupt async reset", 32'(interrupt), 32'h0);
    readStatus("status during reset", 32'h0000_0001);
    tx_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    readStatus("status after mid reset", 32'h0000_0001);

    // Ready while empty must not disturb anything.
    tx_ready = 1'b1;
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
    readStatus("status ready while empty", 32'h0000_0001);
    checkOutput("valid ready while empty", 32'(tx_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
